// File: rtl/ps2_rx_pkg.sv
// Shared PS/2 receive definitions: frame FSM states and line-level constants.
// Also intended for the future host-side transmitter.
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic PS2_START     = 1'b0;
  localparam logic PS2_STOP      = 1'b1;
  localparam int   PS2_DATA_BITS = 8;

endpackage

// File: rtl/ps2_rx_fifo.sv
// Byte FIFO for the PS/2 receiver: circular buffer with a registered head,
// push/pop in the same cycle allowed when full, overflow pulse on a dropped push.
module ps2_rx_fifo #(
  parameter int FIFO_BITS = 3
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic [7:0]           push_data,
  input  logic                 pop,
  output logic [7:0]           head_data,
  output logic                 head_valid,
  output logic                 overflow,
  output logic [FIFO_BITS:0]   level
);

  localparam int DEPTH = 1 << FIFO_BITS;

  logic [7:0]           mem [DEPTH];
  logic [FIFO_BITS-1:0] wr_ptr;
  logic [FIFO_BITS-1:0] rd_ptr;
  logic [FIFO_BITS-1:0] rd_ptr_nx;
  logic [FIFO_BITS:0]   count;
  logic                 full;
  logic                 empty;
  logic                 do_push;
  logic                 do_pop;
  logic                 becomes_head;

  assign full      = (count == (FIFO_BITS+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign rd_ptr_nx = rd_ptr + FIFO_BITS'(1);

  // The pushed byte becomes the head when it will be the only entry left.
  assign becomes_head = do_push & (empty | ((count == (FIFO_BITS+1)'(1)) & do_pop));

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      head_data <= '0;
      overflow  <= 1'b0;
    end else begin
      overflow <= push & full & ~do_pop;
      if (do_push) wr_ptr <= wr_ptr + FIFO_BITS'(1);
      if (do_pop)  rd_ptr <= rd_ptr_nx;
      case ({do_push, do_pop})
        2'b10:   count <= count + (FIFO_BITS+1)'(1);
        2'b01:   count <= count - (FIFO_BITS+1)'(1);
        default: count <= count;
      endcase
      if (becomes_head)
        head_data <= push_data;
      else if (do_pop)
        head_data <= mem[rd_ptr_nx];
    end
  end

  assign head_valid = ~empty;
  assign level      = count;

endmodule

// File: rtl/ps2_host_rx.sv
// PS/2 host receiver: synchronizes and filters the device clock, decodes
// 11-bit frames and buffers bytes. Optional mid-frame timeout: PS2_RX_TIMEOUT_EN.
module ps2_host_rx #(
  parameter int FIFO_BITS   = 3,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 8192
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overflow,
  output logic [FIFO_BITS:0]   fifo_level
);

  import ps2_rx_pkg::*;

  localparam logic [2:0] LAST_BIT = 3'(PS2_DATA_BITS - 1);
  localparam logic [3:0] FILT_END = 4'(FILTER_LEN - 1);

  logic       ps2_clk_p0, ps2_clk_p1;
  logic       ps2_data_p0, ps2_data_p1;
  logic [3:0] filt_cnt;
  logic       filt_clk;
  logic       fe_p2;

  ps2_state_t state, state_nx;
  logic [2:0] bit_cnt;
  logic       par_acc;
  logic       par_ok;
  logic [7:0] shift_p2;
  logic       push_c;
  logic       frame_err_c;
  logic       parity_err_c;
  logic       timeout_hit;

  // Stage p0/p1: two-flop synchronizers, preset to the idle-high line level
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_clk_p0  <= 1'b1;
      ps2_clk_p1  <= 1'b1;
      ps2_data_p0 <= 1'b1;
      ps2_data_p1 <= 1'b1;
    end else begin
      ps2_clk_p0  <= ps2_clk;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_data_p0 <= ps2_data;
      ps2_data_p1 <= ps2_data_p0;
    end
  end

  // Stage p2: level filter; fe_p2 strobes when the accepted level goes 1 -> 0
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      filt_cnt <= '0;
      filt_clk <= 1'b1;
      fe_p2    <= 1'b0;
    end else begin
      fe_p2 <= 1'b0;
      if (ps2_clk_p1 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_END) begin
        filt_cnt <= '0;
        filt_clk <= ps2_clk_p1;
        fe_p2    <= filt_clk;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (timeout_hit) begin
      state_nx = ST_IDLE;
    end else if (fe_p2) begin
      case (state)
        ST_IDLE:   if (ps2_data_p1 == PS2_START) state_nx = ST_DATA;
        ST_DATA:   if (bit_cnt == LAST_BIT) state_nx = ST_PARITY;
        ST_PARITY: state_nx = ST_STOP;
        ST_STOP:   state_nx = ST_IDLE;
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  // A bad stop bit masks a parity failure so each frame reports one error at most
  always_comb begin
    push_c       = 1'b0;
    parity_err_c = 1'b0;
    frame_err_c  = timeout_hit;
    if (fe_p2) begin
      case (state)
        ST_IDLE: frame_err_c = (ps2_data_p1 != PS2_START);
        ST_STOP: begin
          if (ps2_data_p1 != PS2_STOP) frame_err_c  = 1'b1;
          else if (par_ok)             push_c       = 1'b1;
          else                         parity_err_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt       <= '0;
      par_acc       <= 1'b0;
      par_ok        <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_frame_err  <= frame_err_c;
      rx_parity_err <= parity_err_c;
      if (fe_p2) begin
        case (state)
          ST_IDLE: begin
            bit_cnt <= '0;
            par_acc <= 1'b0;
          end
          ST_DATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            par_acc <= par_acc ^ ps2_data_p1;
          end
          ST_PARITY: par_ok <= par_acc ^ ps2_data_p1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (fe_p2 && state == ST_DATA) shift_p2 <= {ps2_data_p1, shift_p2[7:1]};
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);
  // Counter starts the cycle after fe and the error output is registered,
  // so matching TIMEOUT_CYC-2 puts the pulse TIMEOUT_CYC cycles after fe.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 2);

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                       to_cnt <= '0;
    else if (state == ST_IDLE || fe_p2) to_cnt <= '0;
    else                                to_cnt <= to_cnt + TO_W'(1);
  end

  assign timeout_hit = (state != ST_IDLE) && !fe_p2 && (to_cnt == TO_LAST);
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
  assign timeout_hit        = 1'b0;
`endif

  ps2_rx_fifo #(
    .FIFO_BITS (FIFO_BITS)
  ) u_fifo (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .push       (push_c),
    .push_data  (shift_p2),
    .pop        (rx_ready),
    .head_data  (rx_data),
    .head_valid (rx_valid),
    .overflow   (rx_overflow),
    .level      (fifo_level)
  );

endmodule

// File: tb/tb_ps2_host_rx.sv
// Directed bench for ps2_host_rx: device-style frames, error cases, FIFO fill
// and drain, clock glitch filtering, mid-frame reset and optional timeout.
module tb_ps2_host_rx;

  localparam int FIFO_BITS   = 3;
  localparam int FILTER_LEN  = 4;
  localparam int TIMEOUT_CYC = 1000;
  localparam int HALF        = 100;

  logic             clk_sys = 1'b0;
  logic             reset_n = 1'b0;
  logic             ps2_clk = 1'b1;
  logic             ps2_data = 1'b1;
  logic             rx_ready = 1'b1;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_parity_err;
  logic             rx_frame_err;
  logic             rx_overflow;
  logic [FIFO_BITS:0] fifo_level;

  int n_checks = 0;
  int n_errs   = 0;

  int n_valid = 0, n_perr = 0, n_ferr = 0, n_ovf = 0;
  logic [7:0] popped[$];
  int b_valid, b_perr, b_ferr, b_ovf, b_pop;
  int lat;
  int hit;

  ps2_host_rx #(
    .FIFO_BITS   (FIFO_BITS),
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_overflow   (rx_overflow),
    .fifo_level    (fifo_level)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (rx_valid)             n_valid++;
      if (rx_parity_err)        n_perr++;
      if (rx_frame_err)         n_ferr++;
      if (rx_overflow)          n_ovf++;
      if (rx_valid && rx_ready) popped.push_back(rx_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_valid = n_valid;
    b_perr  = n_perr;
    b_ferr  = n_ferr;
    b_ovf   = n_ovf;
    b_pop   = popped.size();
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk_sys);
    #2 rx_ready = r;
  endtask

  // Sends fr[0..nbits-1]; lat = negedges from the last clock fall to the first output event
  task automatic send_bits(input logic [10:0] fr, input int nbits, output int lat_o);
    lat_o = -1;
    for (int i = 0; i < nbits; i++) begin
      lat_o = -1;
      @(negedge clk_sys);
      ps2_data = fr[i];
      repeat (HALF) @(negedge clk_sys);
      ps2_clk = 1'b0;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk_sys);
        if (lat_o < 0 && (rx_valid || rx_parity_err || rx_frame_err)) lat_o = k;
      end
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic flip, input logic stop_b);
    return {stop_b, ~(^d) ^ flip, d, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop_b, output int lat_o);
    send_bits(mk_frame(d, flip, stop_b), 11, lat_o);
    repeat (20) @(negedge clk_sys);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_sys);
    check("reset_valid",  rx_valid, 0);
    check("reset_data",   rx_data, 0);
    check("reset_level",  fifo_level, 0);
    check("reset_pulses", {rx_parity_err, rx_frame_err, rx_overflow}, 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);

    // Good frame 0x1C
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, lat);
    check("good_latency", lat, FILTER_LEN + 3);
    check("good_valid_cycles", n_valid - b_valid, 1);
    check("good_data", popped[b_pop], 8'h1C);
    check("good_no_err", (n_perr - b_perr) + (n_ferr - b_ferr) + (n_ovf - b_ovf), 0);

    // Bad parity
    snap();
    send_frame(8'h1C, 1'b1, 1'b1, lat);
    check("par_latency", lat, FILTER_LEN + 3);
    check("par_err_count", n_perr - b_perr, 1);
    check("par_no_frame_err", n_ferr - b_ferr, 0);
    check("par_no_valid", n_valid - b_valid, 0);
    check("par_level", fifo_level, 0);

    // Bad stop bit
    snap();
    send_frame(8'hF0, 1'b0, 1'b0, lat);
    ps2_data = 1'b1;
    check("stop_latency", lat, FILTER_LEN + 3);
    check("stop_frame_err", n_ferr - b_ferr, 1);
    check("stop_no_par_err", n_perr - b_perr, 0);
    check("stop_no_valid", n_valid - b_valid, 0);

    // Fill to overflow, then drain
    set_ready(1'b0);
    snap();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, lat);
    check("fill_level", fifo_level, 8);
    check("fill_overflow", n_ovf - b_ovf, 1);
    check("fill_valid", rx_valid, 1);
    check("fill_head_stable", rx_data, 8'h01);
    set_ready(1'b1);
    repeat (15) @(negedge clk_sys);
    check("drain_count", popped.size() - b_pop, 8);
    for (int i = 0; i < 8; i++) check("drain_order", popped[b_pop + i], 32'(i + 1));
    check("drain_level", fifo_level, 0);
    check("drain_valid", rx_valid, 0);

    // Glitch of FILTER_LEN-1 cycles is ignored; FILTER_LEN cycles is an edge
    snap();
    @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (FILTER_LEN - 1) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk_sys);
    check("glitch_short_no_edge", n_ferr - b_ferr, 0);
    ps2_clk = 1'b0;
    repeat (FILTER_LEN) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk_sys);
    check("glitch_full_is_edge", n_ferr - b_ferr, 1);
    snap();
    send_frame(8'h5A, 1'b0, 1'b1, lat);
    check("glitch_next_data", popped[b_pop], 8'h5A);
    check("glitch_next_clean", (n_perr - b_perr) + (n_ferr - b_ferr), 0);

`ifdef PS2_RX_TIMEOUT_EN
    // Start + 4 data bits, then idle until the timeout fires
    snap();
    hit = -1;
    send_bits(mk_frame(8'hA5, 1'b0, 1'b1), 5, lat);
    for (int k = 1; k <= TIMEOUT_CYC + 100; k++) begin
      @(negedge clk_sys);
      if (hit < 0 && rx_frame_err) hit = k;
    end
    check("timeout_cycle", hit, FILTER_LEN + 2 + TIMEOUT_CYC - HALF);
    check("timeout_one_err", n_ferr - b_ferr, 1);
    snap();
    send_frame(8'hE0, 1'b0, 1'b1, lat);
    check("timeout_next_data", popped[b_pop], 8'hE0);
    check("timeout_next_count", popped.size() - b_pop, 1);
`endif

    // Reset mid-frame with a byte waiting in the FIFO
    set_ready(1'b0);
    send_frame(8'h33, 1'b0, 1'b1, lat);
    check("pre_reset_level", fifo_level, 1);
    send_bits(mk_frame(8'h12, 1'b0, 1'b1), 6, lat);
    @(negedge clk_sys);
    ps2_data = 1'b0;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    check("midreset_valid", rx_valid, 0);
    check("midreset_level", fifo_level, 0);
    check("midreset_data", rx_data, 0);
    check("midreset_pulses", {rx_parity_err, rx_frame_err, rx_overflow}, 0);
    @(negedge clk_sys);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (20) @(negedge clk_sys);
    reset_n = 1'b1;
    set_ready(1'b1);
    repeat (10) @(negedge clk_sys);
    snap();
    send_frame(8'h12, 1'b0, 1'b1, lat);
    check("postreset_data", popped[b_pop], 8'h12);
    check("postreset_count", popped.size() - b_pop, 1);
    check("postreset_no_err", (n_perr - b_perr) + (n_ferr - b_ferr), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_rx.md
Name: ps2_host_rx

Overview:
Core-side PS/2 host receiver. It is the far end of the keyboard and mouse device emulation in the ARM I/O block: it consumes one ps2 clock/data pair and decodes 11-bit device-to-host frames into bytes. Decoded bytes are buffered in a small FIFO and offered to the core's scancode or mouse logic over a valid/ready handshake. One instance is used per PS/2 channel.

Parameters:
- FIFO_BITS, 3, log2 of the FIFO depth (default 8 entries).
- FILTER_LEN, 4, number of consecutive equal clk_sys samples needed to accept a new ps2_clk level (1..15).
- TIMEOUT_CYC, 8192, idle clk_sys cycles mid-frame before the frame is aborted (optional feature only).

Ports:
- clk_sys  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  PS/2 clock from the device; asynchronous to clk_sys; high when idle.
- ps2_data  in  1  PS/2 data from the device; asynchronous to clk_sys.
- rx_data  out  8  FIFO head byte; valid only while rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts rx_data; a pop occurs when rx_valid & rx_ready.
- rx_parity_err  out  1  one-cycle pulse: parity failed, byte discarded.
- rx_frame_err  out  1  one-cycle pulse: bad start, bad stop or timeout.
- rx_overflow  out  1  one-cycle pulse: good byte arrived while the FIFO was full, byte dropped.
- fifo_level  out  FIFO_BITS+1  number of entries in the FIFO.

Behaviour:
- Reset values (reset_n=0, asynchronous): FSM IDLE; FIFO empty; rx_valid=0; rx_data=0; all pulse outputs=0; fifo_level=0. Synchronizers and filter preset to 1 (line idle).
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - A filtered clock level updates only after FILTER_LEN consecutive identical synchronized samples.
  - A falling edge of the filtered clock is a one-cycle strobe "fe". ps2_data (synchronized) is sampled at that strobe.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on fe, except the timeout.
  - IDLE: data=0 starts a frame → DATA, with bit counter=0 and parity accumulator cleared. data=1 pulses rx_frame_err and stays in IDLE.
  - DATA: shift in LSB first; XOR the bit into the accumulator. After bit 7 → PARITY.
  - PARITY: odd parity is required, i.e. XOR of the 8 data bits and the parity bit must equal 1. Latch the result → STOP.
  - STOP: data=1 with good parity pushes the byte. data=0 pulses rx_frame_err. Otherwise, bad parity pulses rx_parity_err. Bad stop takes precedence, so only one error pulse is issued per frame. Always → IDLE.
- Latency: the pushed byte is visible on rx_data/rx_valid one clk_sys cycle after the stop-bit fe. The pin-to-fe delay is 2 + FILTER_LEN cycles.
- FIFO behaviour:
  - Circular buffer with wrap-around pointers of FIFO_BITS bits plus a separate count.
  - rx_data is the registered head entry; it must not change while rx_valid=1 and rx_ready=0.
  - Push and pop in the same cycle: allowed even when full. The level is unchanged and no overflow occurs.
  - Push while full without a pop: the byte is dropped, rx_overflow is pulsed and the contents are unchanged.
  - Pop while empty: ignored.
- Error pulses are single-cycle and never coincide with a push of the same frame.

Optional Feature:
- Macro: PS2_RX_TIMEOUT_EN.
- When defined: a counter runs while the FSM is not IDLE, resets on every fe, and on reaching TIMEOUT_CYC forces IDLE and pulses rx_frame_err. The partial byte is discarded. This recovers framing after a lost edge.
- When undefined: no counter is built and the FSM waits indefinitely mid-frame. The TIMEOUT_CYC parameter is unused.

Decomposition:
- Package ps2_rx_pkg:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Constants: PS2_START=0, PS2_STOP=1, PS2_DATA_BITS=8.
  - Shared with future host-side transmitter work.
- Sub-module ps2_rx_fifo: parameterised by FIFO_BITS; holds the push/pop/full/empty/level/overflow logic. The top level contains the synchronizers, filter, FSM and timeout.

Test Plan:
- Device-style frame of 0x1C (three ones, parity bit 0, stop 1) with a 200-cycle bit period and rx_ready=1 → rx_valid for one cycle, rx_data=0x1C, no error pulses.
- Same frame with parity bit 1 → single rx_parity_err pulse; rx_valid stays 0; fifo_level=0.
- Frame 0xF0 with stop bit 0 → single rx_frame_err pulse; nothing pushed.
- Nine good frames 0x01..0x09 with rx_ready=0 → fifo_level=8, one rx_overflow on the ninth. Then rx_ready=1 drains 0x01..0x08 in order; the level returns to 0.
- Glitch: ps2_clk low for FILTER_LEN-1 cycles mid-IDLE → no fe, no state change. A subsequent clean frame 0x5A is received correctly.
- Timeout with PS2_RX_TIMEOUT_EN: send start plus 4 data bits, then hold the line idle → rx_frame_err exactly TIMEOUT_CYC cycles after the last fe. The next frame 0xE0 is received correctly.
- Reset mid-frame: assert reset_n=0 during bit 5 → all outputs at reset values immediately. After release, a full frame 0x12 decodes correctly.
